// File: rtl/relu_maxpool_engine.sv
// relu_maxpool_engine: streams a CHW feature map from a read port, applies
// ReLU and (optionally) 2x2/stride-2 max-pooling, and writes results
// sequentially to a write port. One read per cycle, no bubbles.
module relu_maxpool_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 128,
  parameter int IN_HEIGHT  = 6,
  parameter int IN_WIDTH   = 8,
  parameter int POOL_EN    = 1,
  parameter int RD_LATENCY = 1,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         wr_en,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic [DATA_WIDTH-1:0]        wr_data
);
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  localparam int OH   = IN_HEIGHT / 2;
  localparam int OW   = IN_WIDTH / 2;
  localparam int N_RD = (POOL_EN != 0) ? 4 * CHANNELS * OH * OW
                                       : CHANNELS * IN_HEIGHT * IN_WIDTH;

  localparam addr_t A_ONE  = addr_t'(1);
  localparam addr_t A_TWO  = addr_t'(2);
  localparam addr_t A_W    = addr_t'(IN_WIDTH);
  localparam addr_t A_2W   = addr_t'(2 * IN_WIDTH);
  localparam addr_t A_HW   = addr_t'(IN_HEIGHT * IN_WIDTH);
  localparam addr_t A_OW1  = addr_t'(OW - 1);
  localparam addr_t A_OH1  = addr_t'(OH - 1);
  localparam addr_t A_LAST = addr_t'(N_RD - 1);

  state_t      state;
  logic [1:0]  lat_cnt;
  // walker for the read currently on rd_addr: element-in-window, window
  // position and the running base offsets of that window
  logic [1:0]  elem, elem_n;
  addr_t       ox, oy, col, row_base, chan_base, rd_cnt;
  addr_t       ox_n, oy_n, col_n, row_n, chan_n, addr_n;
  logic        rd_first, rd_last, first_n, last_n;

  // tags travel alongside each read so they line up with its returning data
  logic [RD_LATENCY:1] vld_pipe, first_pipe, last_pipe;

  logic signed [DATA_WIDTH-1:0] acc, cand;
  addr_t                        wr_cnt;

  // Next read position and address: (2oy,2ox),(2oy,2ox+1),(2oy+1,2ox),(2oy+1,2ox+1)
  always_comb begin
    elem_n = elem + 2'd1;
    ox_n   = ox;
    oy_n   = oy;
    col_n  = col;
    row_n  = row_base;
    chan_n = chan_base;
    if (elem == 2'd3) begin
      ox_n  = ox + A_ONE;
      col_n = col + A_TWO;
      if (ox == A_OW1) begin
        ox_n  = '0;
        col_n = '0;
        oy_n  = oy + A_ONE;
        row_n = row_base + A_2W;
        if (oy == A_OH1) begin
          oy_n   = '0;
          row_n  = '0;
          chan_n = chan_base + A_HW;
        end
      end
    end
    addr_n = chan_n + row_n + col_n + (elem_n[1] ? A_W : '0) + addr_t'(elem_n[0]);
    if (POOL_EN == 0) addr_n = rd_addr + A_ONE;
    first_n = (POOL_EN == 0) || (elem_n == 2'd0);
    last_n  = (POOL_EN == 0) || (elem_n == 2'd3);
  end

  // Control FSM: issues every read back-to-back, then waits out the latency
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      rd_first  <= 1'b0;
      rd_last   <= 1'b0;
      lat_cnt   <= '0;
      elem      <= '0;
      ox        <= '0;
      oy        <= '0;
      col       <= '0;
      row_base  <= '0;
      chan_base <= '0;
      rd_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            rd_en     <= 1'b1;
            rd_addr   <= '0;
            rd_first  <= 1'b1;
            rd_last   <= (POOL_EN == 0);
            elem      <= '0;
            ox        <= '0;
            oy        <= '0;
            col       <= '0;
            row_base  <= '0;
            chan_base <= '0;
            rd_cnt    <= '0;
          end
        end
        ISSUE: begin
          if (rd_cnt == A_LAST) begin
            rd_en    <= 1'b0;
            rd_first <= 1'b0;
            rd_last  <= 1'b0;
            lat_cnt  <= '0;
            state    <= DRAIN;
          end else begin
            rd_cnt    <= rd_cnt + A_ONE;
            rd_addr   <= addr_n;
            rd_first  <= first_n;
            rd_last   <= last_n;
            elem      <= elem_n;
            ox        <= ox_n;
            oy        <= oy_n;
            col       <= col_n;
            row_base  <= row_n;
            chan_base <= chan_n;
          end
        end
        DRAIN: begin
          // RD_LATENCY cycles for the data, one more for the registered write
          if (lat_cnt == 2'(RD_LATENCY)) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Window reduction: load on first element, signed max on the rest
  always_comb begin
    cand = rd_data;
    if (!first_pipe[RD_LATENCY] && (acc > rd_data)) cand = acc;
  end

  // Tag pipeline, accumulator and rectified write port
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
      acc        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_cnt     <= '0;
    end else begin
      vld_pipe[1]   <= rd_en;
      first_pipe[1] <= rd_first;
      last_pipe[1]  <= rd_last;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe[i]   <= vld_pipe[i-1];
        first_pipe[i] <= first_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
      end
      wr_en <= 1'b0;
      if (state == IDLE) wr_cnt <= '0;
      if (vld_pipe[RD_LATENCY]) begin
        acc <= cand;
        if (last_pipe[RD_LATENCY]) begin
          wr_en   <= 1'b1;
          wr_addr <= wr_cnt;
          wr_data <= cand[DATA_WIDTH-1] ? '0 : cand;
          wr_cnt  <= wr_cnt + A_ONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_relu_maxpool_engine.sv
// tb_relu_maxpool_engine: four engine configurations run side by side, each
// against a memory model and a cycle-exact reference built from plain loops.
module tb_relu_maxpool_engine;
  logic clk;
  int   errors;
  int   checks;
  int   ncyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  localparam int T0 [12] = '{-5, 3, 7, -1, -1, -2, -128, -7, 127, -128, 0, 0};
  localparam int T2 [12] = '{-3, 0, 5, -128, 127, 1, -1, 2, -2, 64, -64, 100};

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag, input logic b, input logic d, input logic re,
                          input logic we, input logic [12:0] ra, input logic [12:0] wa,
                          input logic [7:0] wd);
    chk({tag, "_busy"}, b, 0);
    chk({tag, "_done"}, d, 0);
    chk({tag, "_rd_en"}, re, 0);
    chk({tag, "_wr_en"}, we, 0);
    chk({tag, "_rd_addr"}, ra, 0);
    chk({tag, "_wr_addr"}, wa, 0);
    chk({tag, "_wr_data"}, wd, 0);
  endtask

  // Result of one window: largest of the rectified inputs
  function automatic int win4(int a, int b, int c, int d);
    int m;
    m = 0;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Address of read j straight from the loop nest c / oy / ox / dy / dx
  function automatic int mdl_rd_addr(int pl, int ch, int h, int w, int j);
    int oh, ow, win, e, ox, oy, c;
    if (pl == 0) return j;
    oh  = h / 2;
    ow  = w / 2;
    win = j / 4;
    e   = j % 4;
    ox  = win % ow;
    oy  = (win / ow) % oh;
    c   = win / (ow * oh);
    return c * h * w + (2 * oy + e / 2) * w + 2 * ox + e % 2;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int PL = (g == 2) ? 0 : 1;
    localparam int C  = (g == 0) ? 1 : (g == 3) ? 128 : 2;
    localparam int H  = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 2 : 6;
    localparam int W  = (g == 0) ? 2 : (g == 1) ? 5 : (g == 2) ? 3 : 8;
    localparam int L  = (g == 2) ? 2 : (g == 3) ? 3 : 1;
    localparam int NM = C * H * W;

    logic rst, start, busy, done, rd_en, wr_en;
    logic [12:0] rd_addr, wr_addr;
    logic signed [7:0] rd_data;
    logic [7:0] wr_data;
    logic signed [7:0] mem [NM];
    logic [12:0] adly [4];
    int  t0, nrd, tend, tc, ry, rx;
    bit  run, fin;
    int  exp_ra [$];
    int  ew_addr [int];
    int  ew_data [int];

    relu_maxpool_engine #(
      .DATA_WIDTH(8), .CHANNELS(C), .IN_HEIGHT(H), .IN_WIDTH(W),
      .POOL_EN(PL), .RD_LATENCY(L), .ADDR_WIDTH(13)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    // read port: data for an address appears L cycles after it is presented
    always @(posedge clk) begin
      adly[0] <= rd_addr;
      for (int i = 1; i < 4; i++) adly[i] <= adly[i-1];
    end
    assign rd_data = mem[adly[L-1]];

    // cycle-by-cycle comparison against the reference during a pass
    always @(negedge clk) begin
      tc = ncyc - t0;
      if (run && tc >= 1 && tc <= tend + 1) begin
        chk($sformatf("c%0d_busy@%0d", g, tc), busy, (tc <= tend) ? 1 : 0);
        chk($sformatf("c%0d_done@%0d", g, tc), done, (tc == tend) ? 1 : 0);
        chk($sformatf("c%0d_rd_en@%0d", g, tc), rd_en, (tc <= nrd) ? 1 : 0);
        if (rd_en && tc <= nrd) begin
          chk($sformatf("c%0d_rd_addr@%0d", g, tc), rd_addr, exp_ra[tc-1]);
          ry = (int'(rd_addr) % (H * W)) / W;
          rx = int'(rd_addr) % W;
          chk($sformatf("c%0d_rd_region@%0d", g, tc),
              (ry < ((PL != 0) ? 2 * (H / 2) : H)) && (rx < ((PL != 0) ? 2 * (W / 2) : W)), 1);
        end
        chk($sformatf("c%0d_wr_en@%0d", g, tc), wr_en, ew_addr.exists(tc) ? 1 : 0);
        if (wr_en && ew_addr.exists(tc)) begin
          chk($sformatf("c%0d_wr_addr@%0d", g, tc), wr_addr, ew_addr[tc]);
          chk($sformatf("c%0d_wr_data@%0d", g, tc), int'(wr_data), ew_data[tc]);
        end
      end
    end

    initial begin
      rst = 1'b1; start = 1'b0; run = 1'b0; fin = 1'b0;
      t0 = 0; nrd = 0; tend = 0;
      repeat (2) @(negedge clk);
      chk_zero($sformatf("c%0d_reset", g), busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data);
      rst = 1'b0;
      for (int p = 0; p < 4; p++) begin
        // feature map: literal tables where pinned, random with rail values otherwise
        for (int i = 0; i < NM; i++) begin
          int v;
          v = int'($urandom_range(0, 255)) - 128;
          if ($urandom_range(0, 9) == 0) v = ($urandom_range(0, 1) != 0) ? 127 : -128;
          if (g == 0 && p < 3) v = T0[p*4+i];
          if (g == 2 && p == 0) v = T2[i];
          mem[i] = 8'(v);
        end
        // reference: read order, write cycles and values
        nrd  = (PL != 0) ? 4 * C * (H / 2) * (W / 2) : NM;
        tend = nrd + L + 2;
        exp_ra.delete();
        ew_addr.delete();
        ew_data.delete();
        for (int j = 0; j < nrd; j++) exp_ra.push_back(mdl_rd_addr(PL, C, H, W, j));
        begin
          int gs;
          gs = (PL != 0) ? 4 : 1;
          for (int i = 0; i < nrd / gs; i++) begin
            int cy;
            cy = 2 + i * gs + gs - 1 + L;
            ew_addr[cy] = i;
            ew_data[cy] = win4(int'(mem[exp_ra[i*gs]]), int'(mem[exp_ra[i*gs + (1 % gs)]]),
                               int'(mem[exp_ra[i*gs + (2 % gs)]]), int'(mem[exp_ra[i*gs + (3 % gs)]]));
          end
        end
        if (p == 2) begin
          // abort a pass with a one-cycle reset: no done, no further writes
          @(negedge clk);
          start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
          repeat (2) @(posedge clk);
          @(negedge clk);
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk_zero($sformatf("c%0d_abort", g), busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data);
          for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("c%0d_abort_done", g), done, 0);
            chk($sformatf("c%0d_abort_wr_en", g), wr_en, 0);
          end
        end
        // checked pass; pass 1 also pulses start while busy
        @(negedge clk);
        start = 1'b1;
        t0    = ncyc;
        run   = 1'b1;
        for (int i = 1; i <= tend + 1; i++) begin
          @(posedge clk); #1;
          start = (p == 1 && i == tend / 2);
        end
        run = 1'b0;
      end
      fin = 1'b1;
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    // hand-computed pins for the reference model
    chk("pin_win_mix", win4(-5, 3, 7, -1), 7);
    chk("pin_win_neg", win4(-1, -2, -128, -7), 0);
    chk("pin_win_rail", win4(127, -128, 0, 0), 127);
    chk("pin_relu_neg", win4(-3, -3, -3, -3), 0);
    chk("pin_relu_pos", win4(5, 5, 5, 5), 5);
    chk("pin_addr_c1_j6", mdl_rd_addr(1, 2, 3, 5, 6), 7);
    chk("pin_addr_c1_j13", mdl_rd_addr(1, 2, 3, 5, 13), 18);
    chk("pin_addr_relu", mdl_rd_addr(0, 2, 2, 3, 9), 9);
    chk("pin_addr_dflt_last", mdl_rd_addr(1, 128, 6, 8, 6143), 127 * 48 + 5 * 8 + 7);
    for (int k = 0; k < 40000; k++) begin
      if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) break;
      @(posedge clk);
    end
    chk("all_configs_finished", g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin, 1);
    chk("pin_tend_small", g_cfg[0].tend, 7);
    chk("pin_tend_default", g_cfg[3].tend, 6149);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
